sar_adc_ctrl: RTL and testbench

//  Successive-approximation controller directly downstream of the gate-level latched comparator.

---
 rtl/sar_adc_ctrl_pkg.sv | 27 ++
 rtl/sar_adc_ctrl_if.sv | 35 +++
 rtl/sar_adc_ctrl_cmp_sync.sv | 37 +++
 rtl/sar_adc_ctrl.sv | 157 +++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sar_adc_ctrl_pkg.sv
// +-----------------------------------------------------------------------+
// | Module   : sar_pkg                                                    |
// | Brief    : Shared FSM state type and counter sizing for sar_adc_ctrl  |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

package sar_pkg;

  localparam int unsigned SAR_STATE_W = 3;

  typedef enum logic [SAR_STATE_W-1:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    TRIAL  = 3'd2,
    SETTLE = 3'd3,
    FINISH = 3'd4
  } sar_state_e;

  // Width of a counter that runs 0 .. max_count-1; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count <= 1) ? 1 : $clog2(max_count);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sar_adc_ctrl_if.sv
// +-----------------------------------------------------------------------+
// | Module   : sar_adc_ctrl_if                                            |
// | Brief    : Handshake and analog-front-end signals of the SAR control  |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

interface sar_adc_ctrl_if #(
  parameter int unsigned N_BITS = 8
) ();

  logic              start;
  logic              abort;
  logic              cmp_in;
  logic              cmp_en;
  logic              track_hold;
  logic [N_BITS-1:0] dac_code;
  logic              busy;
  logic              done;
  logic [N_BITS-1:0] result;

  // master: pin wrapper / comparator side; slave: the controller
  modport master (
    output start, abort, cmp_in,
    input  cmp_en, track_hold, dac_code, busy, done, result
  );

  modport slave (
    input  start, abort, cmp_in,
    output cmp_en, track_hold, dac_code, busy, done, result
  );

endinterface

`default_nettype wire

// File: rtl/sar_adc_ctrl_cmp_sync.sv
// +-----------------------------------------------------------------------+
// | Module   : cmp_sync                                                   |
// | Brief    : Flop chain bringing the async comparator output into clk   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

module cmp_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  generate
    if (STAGES < 2) begin : g_stages_chk
      $error("cmp_sync: STAGES must be at least 2");
    end
  endgenerate

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], din};
    end
  end

  assign dout = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/sar_adc_ctrl.sv
// +-----------------------------------------------------------------------+
// | Module   : sar_adc_ctrl                                               |
// | Brief    : Successive-approximation ADC controller, MSB-first trials  |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned N_BITS     = 8,
  parameter int unsigned SAMPLE_CYC = 2,
  parameter int unsigned SETTLE_CYC = 3,
  parameter int unsigned COMP_SYNC  = 2
) (
  input  logic           clk,
  input  logic           rst,
  sar_adc_ctrl_if.slave  bus
);

  generate
    if (SETTLE_CYC < COMP_SYNC + 1) begin : g_settle_chk
      $error("sar_adc_ctrl: SETTLE_CYC must be >= COMP_SYNC+1");
    end
    if (SAMPLE_CYC < 1) begin : g_sample_chk
      $error("sar_adc_ctrl: SAMPLE_CYC must be >= 1");
    end
  endgenerate

  localparam int unsigned CNT_W = cnt_width((SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC);
  localparam int unsigned K_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [CNT_W-1:0] C_SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [K_W-1:0]   C_K_MSB       = K_W'(N_BITS - 1);

  sar_state_e        r_state,  w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
  logic [K_W-1:0]    r_k,      w_k_nxt;
  logic [N_BITS-1:0] r_work,   w_work_nxt;
  logic [N_BITS-1:0] r_dac,    w_dac_nxt;
  logic [N_BITS-1:0] r_result, w_result_nxt;
  logic [N_BITS-1:0] w_work_dec;
  logic              w_cmp;

  cmp_sync #(
    .STAGES (COMP_SYNC)
  ) u_cmp_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.cmp_in),
    .dout (w_cmp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_k      <= '0;
      r_work   <= '0;
      r_dac    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_k      <= w_k_nxt;
      r_work   <= w_work_nxt;
      r_dac    <= w_dac_nxt;
      r_result <= w_result_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_k_nxt      = r_k;
    w_work_nxt   = r_work;
    w_dac_nxt    = r_dac;
    w_result_nxt = r_result;

    // Working register with the bit under trial replaced by the comparator verdict
    w_work_dec      = r_work;
    w_work_dec[r_k] = w_cmp;

    unique case (r_state)
      IDLE: begin
        w_dac_nxt = '0;
        if (bus.start && !bus.abort) begin
          w_state_nxt = SAMPLE;
          w_cnt_nxt   = '0;
          w_work_nxt  = '0;
          w_k_nxt     = C_K_MSB;
        end
      end

      SAMPLE: begin
        if (r_cnt == C_SAMPLE_LAST) begin
          w_state_nxt = TRIAL;
          w_cnt_nxt   = '0;
          w_dac_nxt   = r_work | (N_BITS'(1) << r_k);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      TRIAL: begin
        w_state_nxt = SETTLE;
        w_cnt_nxt   = '0;
      end

      SETTLE: begin
        if (r_cnt == C_SETTLE_LAST) begin
          w_work_nxt = w_work_dec;
          w_cnt_nxt  = '0;
          if (r_k == '0) begin
            w_state_nxt  = FINISH;
            w_result_nxt = w_work_dec;
            w_dac_nxt    = w_work_dec;
          end else begin
            w_state_nxt = TRIAL;
            w_k_nxt     = r_k - K_W'(1);
            w_dac_nxt   = w_work_dec | (N_BITS'(1) << (r_k - K_W'(1)));
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      FINISH: begin
        w_state_nxt = IDLE;
        w_dac_nxt   = '0;
      end

      default: begin
        w_state_nxt = IDLE;
        w_dac_nxt   = '0;
      end
    endcase

    // Cancel overrides everything, including a result about to be committed
    if (bus.abort && (r_state != IDLE)) begin
      w_state_nxt  = IDLE;
      w_dac_nxt    = '0;
      w_result_nxt = r_result;
    end
  end

  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == FINISH);
  assign bus.track_hold = (r_state == SAMPLE);
  assign bus.cmp_en     = (r_state == TRIAL) || (r_state == SETTLE);
  assign bus.dac_code   = r_dac;
  assign bus.result     = r_result;

endmodule

`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
// +-----------------------------------------------------------------------+
// | Module   : tb_sar_adc_ctrl                                            |
// | Brief    : Scoreboard bench for sar_adc_ctrl with comparator model    |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_sar_adc_ctrl;

  localparam int N   = 8;
  localparam int LAT = 35;

  typedef struct {
    logic [7:0]      res;
    int              done_cyc;
    logic [7:0][7:0] trials;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] vin = 8'h00;
  logic       keep_eq = 1'b1;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] seen[$];
  logic [7:0] last_dac = 8'h00;
  logic [7:0] last_done_res = 8'h00;

  sar_adc_ctrl_if #(.N_BITS(N)) bus ();

  sar_adc_ctrl #(
    .N_BITS     (N),
    .SAMPLE_CYC (2),
    .SETTLE_CYC (3),
    .COMP_SYNC  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.cmp_in = (vin > bus.dac_code) || ((vin == bus.dac_code) && keep_eq);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Ideal converter: the result is the largest code the comparator still accepts.
  function automatic exp_t model(input logic [7:0] v, input logic keq, input int s);
    exp_t       e;
    logic [7:0] acc;
    logic [7:0] t;
    acc        = 8'h00;
    e.res      = keq ? v : ((v == 8'h00) ? 8'h00 : v - 8'h01);
    e.done_cyc = s + LAT - 1;
    for (int i = 0; i < 8; i++) begin
      t           = acc | (8'h80 >> i);
      e.trials[i] = t;
      if ((v > t) || ((v == t) && keq)) acc = t;
    end
    return e;
  endfunction

  // Monitor: gathers trial codes and scores each done pulse against the queue
  always @(negedge clk) begin
    if (rst || !bus.busy) begin
      seen.delete();
      last_dac = 8'h00;
    end else if (bus.cmp_en && (bus.dac_code != last_dac)) begin
      seen.push_back(bus.dac_code);
      last_dac = bus.dac_code;
    end
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("result", 32'(bus.result), 32'(mon_e.res));
        chk("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
        chk("trial_count", 32'(seen.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
          if (i < seen.size()) chk($sformatf("trial%0d", i), 32'(seen[i]), 32'(mon_e.trials[i]));
        end
        last_done_res = mon_e.res;
      end
    end
  end

  task automatic launch(input logic [7:0] v, input logic keq, output int s);
    @(negedge clk);
    vin       = v;
    keep_eq   = keq;
    bus.start = 1'b1;
    s         = cyc + 1;
    sb.push_back(model(v, keq, s));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while ((cyc < target) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (((sb.size() != 0) || bus.busy) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_completes"}, 32'((sb.size() != 0) || bus.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({bus.busy, bus.done, bus.cmp_en, bus.track_hold, bus.dac_code, bus.result}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed conversions, including both code extremes
    launch(8'hA5, 1'b1, s);
    chk("track_hold_in_sample", 32'(bus.track_hold), 32'd1);
    wait_idle("conv_a5");
    chk("dac_zero_in_idle", 32'(bus.dac_code), 32'd0);
    launch(8'hFF, 1'b1, s);
    wait_idle("conv_ff");
    launch(8'h00, 1'b1, s);
    wait_idle("conv_00");

    // Back-to-back with start held: second start edge follows one IDLE cycle
    @(negedge clk);
    vin       = 8'h3C;
    keep_eq   = 1'b1;
    bus.start = 1'b1;
    s         = cyc + 1;
    sb.push_back(model(8'h3C, 1'b1, s));
    wait_cyc(s + 35);
    chk("b2b_gap_idle", 32'(bus.busy), 32'd0);
    vin = 8'hC3;
    sb.push_back(model(8'hC3, 1'b1, s + 36));
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("b2b");

    // start re-pulsed mid-conversion is ignored
    launch(8'h5A, 1'b1, s);
    wait_cyc(s + 9);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("restart_ignored");

    // abort in cycle 20
    launch(8'h77, 1'b1, s);
    wait_cyc(s + 19);
    bus.abort = 1'b1;
    sb.delete();
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_front_end", 32'({bus.cmp_en, bus.track_hold, bus.dac_code}), 32'd0);
    chk("abort_result_kept", 32'(bus.result), 32'(last_done_res));
    repeat (40) @(negedge clk);

    // abort and start together in IDLE: abort wins
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_beats_start", 32'(bus.busy), 32'd0);

    // Asynchronous reset between edges mid-conversion
    launch(8'h96, 1'b1, s);
    wait_cyc(s + 14);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("async_reset_outputs", 32'({bus.busy, bus.done, bus.cmp_en, bus.track_hold, bus.dac_code}), 32'd0);
    chk("async_reset_result", 32'(bus.result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_done_res = 8'h00;
    launch(8'h69, 1'b1, s);
    wait_idle("after_reset");

    // Randomized codes and comparator tie behaviour, with random idle gaps
    for (int i = 0; i < 12; i++) begin
      launch(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), s);
      wait_idle("random");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
